// File: rtl/pts_16.sv
// pts_16: parallel-to-serial converter for the FFT datapath.
// Captures an N-word frame in one handshake and streams it out word 0 first.
module pts_16 #(
  parameter int DW = 16,
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] din,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_d,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] frame_q [N];
  logic [DW-1:0] frame_d [N];

  logic at_last;
  logic load;
  logic out_hs;

  assign at_last   = (idx_q == IW'(N-1));
  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;
  assign out_d     = frame_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = out_valid & at_last;

  // Ready on the final beat so the next frame loads with no bubble.
  assign in_ready = (state_q == IDLE) |
                    ((state_q == SHIFT) & at_last & out_ready);

  assign load   = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int i = 0; i < N; i++) begin
      frame_d[i] = frame_q[i];
    end
    if (load) begin
      for (int i = 0; i < N; i++) begin
        frame_d[i] = din[i*DW +: DW];
      end
      idx_d   = '0;
      state_d = SHIFT;
    end else if (out_hs) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < N; i++) begin
        frame_q[i] <= frame_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pts_16.sv
// tb_pts_16: directed self-checking bench for pts_16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pts_16;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int IW = 4;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] din;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_d;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;

  int checks = 0;
  int errors = 0;

  pts_16 #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] base);
    logic [N*DW-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[k*DW +: DW] = base + DW'(k);
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] w,
                          input int k, input logic rdy);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_d"}, 32'(out_d), 32'(w));
    chk({tag, "_idx"}, 32'(out_idx), 32'(k));
    chk({tag, "_last"}, 32'(out_last), 32'(k == N-1));
    chk({tag, "_inrdy"}, 32'(in_ready), 32'(rdy));
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of word 0.
  task automatic load(input logic [DW-1:0] base);
    din      = mk(base);
    in_valid = 1'b1;
    chk("load_inrdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk_idle("idle");
      chk("idle_d", 32'(out_d), 32'd0);
      chk("idle_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
    end

    // Single frame, no stall
    load(16'h1000);
    for (int k = 0; k < N; k++) begin
      chk_word("single", 16'h1000 + DW'(k), k, k == N-1);
      @(negedge clk);
    end
    chk_idle("single_end");

    // Backpressure: 3-cycle stall at word 5
    load(16'h1000);
    for (int k = 0; k < N; k++) begin
      if (k == 5) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk_word("stall", 16'h1005, 5, 1'b0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk_word("bp", 16'h1000 + DW'(k), k, k == N-1);
      @(negedge clk);
    end
    chk_idle("bp_end");

    // Back-to-back frames A then B
    load(16'hA000);
    in_valid = 1'b1;
    din      = mk(16'hB000);
    for (int k = 0; k < 2*N; k++) begin
      if (k < N) begin
        chk_word("b2b_a", 16'hA000 + DW'(k), k, k == N-1);
      end else begin
        chk_word("b2b_b", 16'hB000 + DW'(k-N), k-N, k == 2*N-1);
      end
      @(negedge clk);
      if (k == N-1) in_valid = 1'b0;
    end
    chk_idle("b2b_end");

    // Reset mid-frame at index 7
    load(16'h1000);
    repeat (7) @(negedge clk);
    chk("mid_idx7", 32'(out_idx), 32'd7);
    chk("mid_d7", 32'(out_d), 32'h1007);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_idle("rst_mid");
    chk("rst_mid_idx", 32'(out_idx), 32'd0);
    chk("rst_mid_d", 32'(out_d), 32'd0);
    @(negedge clk);
    chk_idle("rst_mid2");
    load(16'hC000);
    for (int k = 0; k < N; k++) begin
      chk_word("after_rst", 16'hC000 + DW'(k), k, k == N-1);
      @(negedge clk);
    end
    chk_idle("after_rst_end");

    // Input isolation: din scrambled after the load edge
    load(16'hD000);
    for (int k = 0; k < N; k++) begin
      din = {8{$urandom()}};
      chk_word("iso", 16'hD000 + DW'(k), k, k == N-1);
      @(negedge clk);
    end
    chk_idle("iso_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
